cell_stream_ibuf: RTL and testbench

Input buffer and serializer for the cell-controller stream packet path. Accepts a flattened 4-word packet (header, X, Y, sum) on a one-cycle strobe, queues it in a small packet FIFO, and emits it as a 4-beat valid/ready/last stream (header first, tlast on sum). It sits directly upstream of the stream output buffer / packet MUX and absorbs downstream back-pressure; overflow is counted, never stalls the producer.

---
 rtl/cell_stream_ibuf_if.sv | 50 +++++
 rtl/cell_stream_ibuf.sv | 149 ++++++++++++++
 tb/tb_cell_stream_ibuf.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cell_stream_ibuf_if.sv
`default_nettype none
// ============================================================================
//  Module      : cell_stream_ibuf_if
//  Description : Bundle for the cell_stream_ibuf packet input strobe and its
//                valid/ready/last output stream. The master side is the
//                environment: it drives the packet strobe and the downstream
//                tready. The slave side is the buffer itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface cell_stream_ibuf_if;

    // Flattened 4-word packet, presented on a one-cycle strobe
    logic        stream_in_valid;
    logic [31:0] stream_in_header;
    logic [31:0] stream_in_datax;
    logic [31:0] stream_in_datay;
    logic [31:0] stream_in_datas;

    // Serialized output stream
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [31:0] tdata;

    modport master (
        output stream_in_valid,
        output stream_in_header,
        output stream_in_datax,
        output stream_in_datay,
        output stream_in_datas,
        output tready,
        input  tvalid,
        input  tlast,
        input  tdata
    );

    modport slave (
        input  stream_in_valid,
        input  stream_in_header,
        input  stream_in_datax,
        input  stream_in_datay,
        input  stream_in_datas,
        input  tready,
        output tvalid,
        output tlast,
        output tdata
    );

endinterface
`default_nettype wire

// File: rtl/cell_stream_ibuf.sv
`default_nettype none
// ============================================================================
//  Module      : cell_stream_ibuf
//  Description : Packet FIFO and serializer for the cell-controller stream
//                path. A 4-word packet arrives on a one-cycle strobe, is held
//                in one of 2**DEPTH_LOG2 slots and leaves as a 4-beat
//                valid/ready/last stream (header first, tlast on the sum
//                word). A packet arriving while full is dropped and flagged.
//                Optional feature macro: CELL_STREAM_IBUF_DROPCNT_EN enables a
//                16-bit saturating dropped-packet counter; without it
//                drop_count reads as zero.
//  Revision    : 1.0  initial release
// ============================================================================
module cell_stream_ibuf #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    cell_stream_ibuf_if.slave     bus,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic [15:0]           drop_count
);

    localparam int unsigned         C_DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_FULL      = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [1:0]          C_LAST_WORD = 2'd3;

    // Packet storage: one row of four words per slot; never reset
    logic [31:0] mem_q [C_DEPTH][4];

    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [1:0]            widx_q, widx_d;
    logic [DEPTH_LOG2:0]   occ_q,  occ_d;
    logic                  overflow_q, overflow_d;

    logic w_tvalid;
    logic w_full;
    logic w_xfer;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Handshake decode; a slot freed by a pop can take a new packet the same cycle
    always_comb begin
        w_tvalid = (occ_q != '0);
        w_full   = (occ_q == C_FULL);
        w_xfer   = w_tvalid & bus.tready;
        w_pop    = w_xfer & (widx_q == C_LAST_WORD);
        w_push   = bus.stream_in_valid & (~w_full | w_pop);
        w_drop   = bus.stream_in_valid & w_full & ~w_pop;
    end

    // Next-state for pointers, word index, occupancy and the sticky flag
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        widx_d     = widx_q;
        occ_d      = occ_q;
        overflow_d = overflow_q;

        if (w_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        // The 2-bit index wraps 3 -> 0 on its own at the packet boundary
        if (w_xfer) begin
            widx_d = widx_q + 2'd1;
        end
        if (w_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        // A drop outranks a clear in the same cycle
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Control state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            widx_q     <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            widx_q     <= widx_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
        end
    end

    // Slot write: all four words land together at the write pointer
    always_ff @(posedge clk) begin
        if (resetn && w_push) begin
            mem_q[wptr_q][0] <= bus.stream_in_header;
            mem_q[wptr_q][1] <= bus.stream_in_datax;
            mem_q[wptr_q][2] <= bus.stream_in_datay;
            mem_q[wptr_q][3] <= bus.stream_in_datas;
        end
    end

`ifdef CELL_STREAM_IBUF_DROPCNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Dropped-packet counter, saturating at all-ones
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (w_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 16'h0;
`endif

    // Output stream is a pure function of registered state; zero data when idle
    assign bus.tvalid = w_tvalid;
    assign bus.tlast  = w_tvalid & (widx_q == C_LAST_WORD);
    assign bus.tdata  = w_tvalid ? mem_q[rptr_q][widx_q] : 32'h0;

    assign fill     = occ_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_cell_stream_ibuf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cell_stream_ibuf
//  Description : Self-checking bench for cell_stream_ibuf (DEPTH_LOG2 = 2).
//                A queue-of-packets reference model tracks expected stream
//                output, fill, overflow and drop count every cycle; a vector
//                table and hand sequences pin down the documented scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cell_stream_ibuf;

    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef CELL_STREAM_IBUF_DROPCNT_EN
    localparam int DC_ON = 1;
`else
    localparam int DC_ON = 0;
`endif

    typedef logic [3:0][31:0] pkt_t;   // [0] = header ... [3] = sum

    typedef struct {
        bit          v;
        pkt_t        p;
        bit          rdy;
        bit          exp_tv;
        logic [31:0] exp_data;
        bit          exp_last;
        int          exp_fill;
    } vec_t;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                overflow_clr = 1'b0;
    logic [DEPTH_LOG2:0] fill;
    logic                overflow;
    logic [15:0]         drop_count;

    cell_stream_ibuf_if bus ();

    cell_stream_ibuf #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus),
        .fill         (fill),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    pkt_t mq[$];
    int   mb   = 0;
    bit   m_ovf = 1'b0;
    int   m_dc = 0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %08h expected %08h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_dc();
        return (DC_ON != 0) ? 32'(m_dc) : 32'h0;
    endfunction

    function automatic pkt_t mkpkt(input int i);
        pkt_t p;
        for (int w = 0; w < 4; w++) p[w] = 32'hB000_0000 | 32'(i << 8) | 32'(w);
        return p;
    endfunction

    // One clock: drive inputs, compare outputs with the model, advance the model
    task automatic step(input bit v, input pkt_t p, input bit rdy, input bit clr);
        bit          tv;
        bit          pop;
        logic [31:0] ed;
        bus.stream_in_valid  = v;
        bus.stream_in_header = p[0];
        bus.stream_in_datax  = p[1];
        bus.stream_in_datay  = p[2];
        bus.stream_in_datas  = p[3];
        bus.tready           = rdy;
        overflow_clr         = clr;
        #1;
        tv = (mq.size() != 0);
        ed = 32'h0;
        if (tv) ed = mq[0][mb];
        chk("tvalid",     32'(bus.tvalid), 32'(tv));
        chk("tdata",      bus.tdata, ed);
        chk("tlast",      32'(bus.tlast), 32'(tv && (mb == 3)));
        chk("fill",       32'(fill), 32'(mq.size()));
        chk("overflow",   32'(overflow), 32'(m_ovf));
        chk("drop_count", 32'(drop_count), exp_dc());

        if (!resetn) begin
            mq.delete();
            mb    = 0;
            m_ovf = 1'b0;
            m_dc  = 0;
        end else begin
            pop = 1'b0;
            if (tv && rdy) begin
                if (mb == 3) begin
                    mb  = 0;
                    pop = 1'b1;
                end else begin
                    mb++;
                end
            end
            if (v && mq.size() == DEPTH && !pop) begin
                m_ovf = 1'b1;
                if (m_dc != 65535) m_dc++;
            end else begin
                if (v) begin
                    // accepted; a same-cycle pop frees the head slot first
                end else if (clr) begin
                    m_ovf = 1'b0;
                end
                if (v && clr) m_ovf = 1'b0;
            end
            if (pop) void'(mq.pop_front());
            if (v && (mq.size() < DEPTH)) mq.push_back(p);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy, 1'b0);
    endtask

    vec_t tbl[$];
    pkt_t pa;
    pkt_t pr;
    int   beats;

    initial begin
        bus.stream_in_valid  = 1'b0;
        bus.stream_in_header = '0;
        bus.stream_in_datax  = '0;
        bus.stream_in_datay  = '0;
        bus.stream_in_datas  = '0;
        bus.tready           = 1'b0;

        pa = {32'h33, 32'h22, 32'h11, 32'hA000_0001};

        // Single packet with tready=1, then the same packet under back-pressure
        tbl.push_back('{1'b1, pa, 1'b1, 1'b0, 32'h0,        1'b0, 0});
        tbl.push_back('{1'b0, '0, 1'b1, 1'b1, 32'hA0000001, 1'b0, 1});
        tbl.push_back('{1'b0, '0, 1'b1, 1'b1, 32'h11,       1'b0, 1});
        tbl.push_back('{1'b0, '0, 1'b1, 1'b1, 32'h22,       1'b0, 1});
        tbl.push_back('{1'b0, '0, 1'b1, 1'b1, 32'h33,       1'b1, 1});
        tbl.push_back('{1'b0, '0, 1'b1, 1'b0, 32'h0,        1'b0, 0});
        tbl.push_back('{1'b1, pa, 1'b0, 1'b0, 32'h0,        1'b0, 0});
        tbl.push_back('{1'b0, '0, 1'b1, 1'b1, 32'hA0000001, 1'b0, 1});
        tbl.push_back('{1'b0, '0, 1'b0, 1'b1, 32'h11,       1'b0, 1});
        tbl.push_back('{1'b0, '0, 1'b0, 1'b1, 32'h11,       1'b0, 1});
        tbl.push_back('{1'b0, '0, 1'b1, 1'b1, 32'h11,       1'b0, 1});
        tbl.push_back('{1'b0, '0, 1'b0, 1'b1, 32'h22,       1'b0, 1});
        tbl.push_back('{1'b0, '0, 1'b0, 1'b1, 32'h22,       1'b0, 1});
        tbl.push_back('{1'b0, '0, 1'b1, 1'b1, 32'h22,       1'b0, 1});
        tbl.push_back('{1'b0, '0, 1'b0, 1'b1, 32'h33,       1'b1, 1});
        tbl.push_back('{1'b0, '0, 1'b0, 1'b1, 32'h33,       1'b1, 1});
        tbl.push_back('{1'b0, '0, 1'b1, 1'b1, 32'h33,       1'b1, 1});
        tbl.push_back('{1'b0, '0, 1'b1, 1'b0, 32'h0,        1'b0, 0});

        // Reset and reset-state values
        resetn = 1'b0;
        idle(1'b1, 3);
        resetn = 1'b1;
        chk("rst_tvalid",   32'(bus.tvalid), 32'h0);
        chk("rst_tlast",    32'(bus.tlast), 32'h0);
        chk("rst_tdata",    bus.tdata, 32'h0);
        chk("rst_fill",     32'(fill), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_dropcnt",  32'(drop_count), 32'h0);
        idle(1'b1, 5);

        // Vector table: rows are checked against fixed expectations as well
        for (int i = 0; i < tbl.size(); i++) begin
            chk("tbl_tvalid", 32'(bus.tvalid), 32'(tbl[i].exp_tv));
            chk("tbl_tdata",  bus.tdata, tbl[i].exp_data);
            chk("tbl_tlast",  32'(bus.tlast), 32'(tbl[i].exp_last));
            chk("tbl_fill",   32'(fill), 32'(tbl[i].exp_fill));
            step(tbl[i].v, tbl[i].p, tbl[i].rdy, 1'b0);
        end

        // Fill to full with tready low; the fifth strobe is dropped
        for (int i = 0; i < 5; i++) step(1'b1, mkpkt(i), 1'b0, 1'b0);
        chk("full_fill",     32'(fill), 32'd4);
        chk("full_overflow", 32'(overflow), 32'd1);
        chk("full_dropcnt",  32'(drop_count), 32'(DC_ON));
        beats = 0;
        for (int k = 0; k < 16; k++) begin
            chk("drain_tvalid", 32'(bus.tvalid), 32'd1);
            chk("drain_tdata",  bus.tdata, 32'hB000_0000 | 32'((k / 4) << 8) | 32'(k % 4));
            if (bus.tvalid === 1'b1) beats++;
            step(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drain_beats", 32'(beats), 32'd16);
        chk("drain_empty", 32'(bus.tvalid), 32'd0);

        // Push while full, in the cycle the head packet's last beat transfers
        step(1'b0, '0, 1'b0, 1'b1);
        chk("clr_overflow", 32'(overflow), 32'd0);
        for (int i = 10; i < 14; i++) step(1'b1, mkpkt(i), 1'b0, 1'b0);
        idle(1'b1, 3);
        chk("pwf_last_beat", 32'(bus.tlast), 32'd1);
        step(1'b1, mkpkt(14), 1'b1, 1'b0);
        chk("pwf_fill",     32'(fill), 32'd4);
        chk("pwf_overflow", 32'(overflow), 32'd0);
        chk("pwf_head",     bus.tdata, 32'hB000_0B00);
        idle(1'b1, 17);

        // Reset in the middle of a packet
        step(1'b1, mkpkt(20), 1'b1, 1'b0);
        idle(1'b1, 2);
        resetn = 1'b0;
        step(1'b0, '0, 1'b1, 1'b0);
        resetn = 1'b1;
        chk("midrst_tvalid", 32'(bus.tvalid), 32'd0);
        chk("midrst_fill",   32'(fill), 32'd0);
        step(1'b1, mkpkt(21), 1'b1, 1'b0);
        chk("midrst_tvalid2", 32'(bus.tvalid), 32'd1);
        chk("midrst_header",  bus.tdata, 32'hB000_1500);
        idle(1'b1, 5);

        // Clear racing a drop: the drop wins, a lone clear then clears
        for (int i = 30; i < 34; i++) step(1'b1, mkpkt(i), 1'b0, 1'b0);
        step(1'b1, mkpkt(34), 1'b0, 1'b1);
        chk("race_overflow", 32'(overflow), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("race_cleared", 32'(overflow), 32'd0);
        idle(1'b1, 17);

        // Randomized traffic against the model, including rare resets
        for (int i = 0; i < 800; i++) begin
            for (int w = 0; w < 4; w++) pr[w] = $urandom;
            resetn = ($urandom_range(0, 299) != 0);
            step($urandom_range(0, 99) < 45, pr, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 5);
        end
        resetn = 1'b1;
        idle(1'b1, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
